// File: rtl/dadda_8x8_pkg.sv
// Shared widths for the 8x8 Dadda multiplier.
//   WIDTH_IN  : operand width
//   WIDTH_OUT : product width
package dadda_8x8_pkg;

  localparam int unsigned WIDTH_IN  = 8;
  localparam int unsigned WIDTH_OUT = 16;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder; doubles as a half adder when cin_i is tied low.
//   a_i, b_i, cin_i : addend bits
//   sum_o           : sum bit (same weight)
//   cout_o          : carry bit (next weight)
module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/dadda_8x8.sv
// Unsigned 8x8 -> 16 multiplier: AND-array partial products, four Dadda reduction
// stages (heights 8 -> 6 -> 4 -> 3 -> 2), a ripple-carry CPA and one output register.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset, clears y
//   A, B  : unsigned operands
//   y     : registered product A*B, valid one cycle after sampling
module dadda_8x8
  import dadda_8x8_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH_IN-1:0]  A,
  input  logic [WIDTH_IN-1:0]  B,
  output logic [WIDTH_OUT-1:0] y
);

  localparam int NumCols   = 2 * WIDTH_IN - 1;
  localparam int NumStages = 4;
  localparam int MaxH      = WIDTH_IN;

  // Full adders placed in column c of stage s (stage 0 reduces 8 -> 6).
  function automatic int fa_cnt(int s, int c);
    case (s)
      0:       return (c >= 7 && c <= 9) ? 1 : 0;
      1:       return (c == 5 || c == 11) ? 1 : ((c >= 6 && c <= 10) ? 2 : 0);
      2:       return (c >= 4 && c <= 12) ? 1 : 0;
      3:       return (c >= 3 && c <= 13) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Half adders placed in column c of stage s.
  function automatic int ha_cnt(int s, int c);
    case (s)
      0:       return (c >= 6 && c <= 8) ? 1 : 0;
      1:       return (c == 4 || c == 5) ? 1 : 0;
      2:       return (c == 3) ? 1 : 0;
      3:       return (c == 2) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  // Height of column c at the input of stage s, replaying the adder placement.
  function automatic int col_height(int s, int c);
    logic [4*NumCols-1:0] hv;
    int carry;
    int nh;
    for (int cc = 0; cc < NumCols; cc++) begin
      hv[4*cc +: 4] = (cc < MaxH) ? 4'(cc + 1) : 4'(NumCols - cc);
    end
    for (int ss = 0; ss < s; ss++) begin
      carry = 0;
      for (int cc = 0; cc < NumCols; cc++) begin
        nh    = int'(hv[4*cc +: 4]) - 2 * fa_cnt(ss, cc) - ha_cnt(ss, cc) + carry;
        carry = fa_cnt(ss, cc) + ha_cnt(ss, cc);
        hv[4*cc +: 4] = 4'(nh);
      end
    end
    return int'(hv[4*c +: 4]);
  endfunction

  // dots[s][c][b]: bit b of column c entering stage s; slots above the height are 0.
  logic dots   [NumStages+1][NumCols][MaxH];
  logic fa_sum [NumStages][NumCols][2];
  logic fa_cy  [NumStages][NumCols][2];
  logic ha_sum [NumStages][NumCols];
  logic ha_cy  [NumStages][NumCols];

  // Partial products: column c holds A[c-r] & B[r] for every valid row r.
  for (genvar c = 0; c < NumCols; c++) begin : g_pp
    for (genvar b = 0; b < MaxH; b++) begin : g_bit
      localparam int Row = ((c > MaxH - 1) ? c - (MaxH - 1) : 0) + b;
      if (b < col_height(0, c)) begin : g_dot
        assign dots[0][c][b] = A[c-Row] & B[Row];
      end else begin : g_zero
        assign dots[0][c][b] = 1'b0;
      end
    end
  end

  // Each stage consumes the low dots of a column in its adders and passes the rest.
  // Output column order: untouched dots, FA sums, HA sum, carries from column c-1.
  for (genvar s = 0; s < NumStages; s++) begin : g_stage
    for (genvar c = 0; c < NumCols; c++) begin : g_col
      localparam int H    = col_height(s, c);
      localparam int Nf   = fa_cnt(s, c);
      localparam int Nh   = ha_cnt(s, c);
      localparam int Np   = H - 3 * Nf - 2 * Nh;
      localparam int NfIn = (c > 0) ? fa_cnt(s, c - 1) : 0;
      localparam int NhIn = (c > 0) ? ha_cnt(s, c - 1) : 0;

      for (genvar k = 0; k < 2; k++) begin : g_fa
        if (k < Nf) begin : g_on
          full_adder u_fa (
            .a_i   (dots[s][c][3*k]),
            .b_i   (dots[s][c][3*k+1]),
            .cin_i (dots[s][c][3*k+2]),
            .sum_o (fa_sum[s][c][k]),
            .cout_o(fa_cy[s][c][k])
          );
        end else begin : g_off
          assign fa_sum[s][c][k] = 1'b0;
          assign fa_cy[s][c][k]  = 1'b0;
        end
      end

      if (Nh > 0) begin : g_ha
        full_adder u_ha (
          .a_i   (dots[s][c][3*Nf]),
          .b_i   (dots[s][c][3*Nf+1]),
          .cin_i (1'b0),
          .sum_o (ha_sum[s][c]),
          .cout_o(ha_cy[s][c])
        );
      end else begin : g_no_ha
        assign ha_sum[s][c] = 1'b0;
        assign ha_cy[s][c]  = 1'b0;
      end

      for (genvar b = 0; b < MaxH; b++) begin : g_out
        if (b < Np) begin : g_pass
          assign dots[s+1][c][b] = dots[s][c][3*Nf+2*Nh+b];
        end else if (b < Np + Nf) begin : g_fsum
          assign dots[s+1][c][b] = fa_sum[s][c][b-Np];
        end else if (b < Np + Nf + Nh) begin : g_hsum
          assign dots[s+1][c][b] = ha_sum[s][c];
        end else if (b < Np + Nf + Nh + NfIn) begin : g_fcy
          assign dots[s+1][c][b] = fa_cy[s][c-1][b-Np-Nf-Nh];
        end else if (b < Np + Nf + Nh + NfIn + NhIn) begin : g_hcy
          assign dots[s+1][c][b] = ha_cy[s][c-1];
        end else begin : g_zero
          assign dots[s+1][c][b] = 1'b0;
        end
      end
    end
  end

  // Final two rows: ripple-carry adder; carry out of the top column is bit 15.
  logic [WIDTH_OUT-1:0] y_d;
  logic                 cpa_cy [NumCols+1];

  assign cpa_cy[0] = 1'b0;
  for (genvar c = 0; c < NumCols; c++) begin : g_cpa
    full_adder u_cpa (
      .a_i   (dots[NumStages][c][0]),
      .b_i   (dots[NumStages][c][1]),
      .cin_i (cpa_cy[c]),
      .sum_o (y_d[c]),
      .cout_o(cpa_cy[c+1])
    );
  end
  assign y_d[WIDTH_OUT-1] = cpa_cy[NumCols];

  logic [WIDTH_OUT-1:0] y_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign y = y_q;

endmodule

// File: tb/tb_dadda_8x8.sv
// Self-checking bench for dadda_8x8: reset, corners, latency, input hold, ramp with a
// mid-stream reset, randomized vectors and an exhaustive sweep, all against A*B.
module tb_dadda_8x8;

  logic        clk;
  logic        rst_n;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [15:0] y;

  int n_vec;
  int n_err;

  dadda_8x8 u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .A    (A),
    .B    (B),
    .y    (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: y=%h expected %h (A=%0d B=%0d)", tag, got, exp, A, B);
    end
  endtask

  // Reference product: plain integer multiply, or zero when reset is sampled.
  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic rst);
    int p;
    p = int'(a) * int'(b);
    return rst ? 16'(p) : 16'h0000;
  endfunction

  // Drive inputs, let one rising edge sample them, check just after the edge.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic rst,
                      input string tag);
    A     = a;
    B     = b;
    rst_n = rst;
    @(posedge clk);
    #1;
    check_eq(tag, y, model(a, b, rst));
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rr;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    A     = 8'hFF;
    B     = 8'hFF;
    #2;

    step(8'hFF, 8'hFF, 1'b0, "reset0");
    step(8'hFF, 8'hFF, 1'b0, "reset1");
    step(8'hFF, 8'hFF, 1'b1, "release");

    step(8'd0,   8'd0,   1'b1, "zero");
    step(8'd1,   8'd1,   1'b1, "one");
    step(8'd255, 8'd1,   1'b1, "ff_x1");
    step(8'd128, 8'd2,   1'b1, "msb_x2");
    step(8'd255, 8'd255, 1'b1, "max");

    step(8'd3, 8'd5, 1'b1, "lat_n");
    step(8'd7, 8'd9, 1'b1, "lat_n1");

    // Inputs moving mid-cycle must not disturb the registered product.
    step(8'd13, 8'd11, 1'b1, "pre_hold");
    A = 8'd200;
    B = 8'd200;
    #3;
    check_eq("hold", y, 16'd143);

    // Ramp: A moves just after the edge, B half a cycle later; one reset cycle inside.
    for (int i = 0; i < 258; i++) begin
      A = 8'(i);
      @(negedge clk);
      B     = 8'(i);
      rst_n = (i != 100);
      @(posedge clk);
      #1;
      check_eq((i == 100) ? "ramp_rst" : "ramp", y, model(8'(i), 8'(i), i != 100));
    end

    for (int i = 0; i < 1500; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rr = ($urandom_range(0, 31) != 0);
      step(ra, rb, rr, "rand");
    end

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        step(8'(a), 8'(b), 1'b1, "exh");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
